// File: rtl/multi_delay_timer_if.sv
// Bundle of per-channel start/cancel/delay requests and timer status flags.
// The master drives requests and the slave (the timer) drives status.
interface multi_delay_timer_if #(
  parameter int NUM_CH = 4,
  parameter int UNIT_W = 8
);
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        cancel;
  logic [NUM_CH*UNIT_W-1:0] units;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH-1:0]        busy;
  logic                     any_busy;
  logic [NUM_CH-1:0]        reject;
  logic [NUM_CH*UNIT_W-1:0] remaining;

  modport master (
    output start, cancel, units,
    input  enable, busy, any_busy, reject, remaining
  );

  modport slave (
    input  start, cancel, units,
    output enable, busy, any_busy, reject, remaining
  );
endinterface

// File: rtl/multi_delay_timer.sv
// Bank of independent delay timers; each channel counts a captured number of
// "minutes" of TICKS_PER_UNIT clocks and pulses enable in its final cycle.
module multi_delay_timer #(
  parameter int NUM_CH         = 4,
  parameter int UNIT_W         = 8,
  parameter int TICKS_PER_UNIT = 12500000,
  parameter int EXCLUSIVE      = 0
) (
  input logic clk,
  input logic reset,
  multi_delay_timer_if.slave bus
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_UNIT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [NUM_CH-1:0]        want;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        busy_w;
  logic [NUM_CH-1:0]        enable_w;
  logic [NUM_CH-1:0]        reject_w;
  logic [NUM_CH*UNIT_W-1:0] remaining_w;

  // In exclusive mode nothing starts while any channel is busy (its enable
  // cycle included), and the lowest requesting index wins the arbitration.
  always_comb begin
    grant = want;
    if (EXCLUSIVE != 0) begin
      grant = (|busy_w) ? '0 : (want & (~want + NUM_CH'(1)));
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [0:0]        state;
      logic [PW-1:0]     pres;
      logic [UNIT_W-1:0] cnt;
      logic              rej;
      logic [UNIT_W-1:0] unit_in;
      logic              wrap;
      logic              last;

      assign unit_in = bus.units[i*UNIT_W +: UNIT_W];
      assign want[i] = (state == IDLE) && bus.start[i] && !bus.cancel[i] &&
                       (unit_in != '0);
      assign wrap    = (pres == PRE_MAX);
      assign last    = (state == RUN) && wrap && (cnt == UNIT_W'(1));

      assign busy_w[i]                        = (state == RUN);
      assign enable_w[i]                      = last;
      assign reject_w[i]                      = rej;
      assign remaining_w[i*UNIT_W +: UNIT_W]  = cnt;

      // A refused start is any idle, uncancelled request that was not granted,
      // whether for a zero delay or for losing exclusive arbitration.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= IDLE;
          pres  <= '0;
          cnt   <= '0;
          rej   <= 1'b0;
        end else begin
          rej <= (state == IDLE) && bus.start[i] && !bus.cancel[i] && !grant[i];
          if (state == IDLE) begin
            if (grant[i]) begin
              state <= RUN;
              pres  <= '0;
              cnt   <= unit_in;
            end
          end else if (bus.cancel[i] || last) begin
            state <= IDLE;
            pres  <= '0;
            cnt   <= '0;
          end else if (wrap) begin
            pres <= '0;
            if (cnt != '0) cnt <= cnt - UNIT_W'(1);
          end else begin
            pres <= pres + PW'(1);
          end
        end
      end
    end
  endgenerate

  assign bus.busy      = busy_w;
  assign bus.any_busy  = |busy_w;
  assign bus.enable    = enable_w;
  assign bus.reject    = reject_w;
  assign bus.remaining = remaining_w;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed bench for multi_delay_timer: one independent and one exclusive
// instance, expected per-cycle outputs queued on a scoreboard.
module tb_multi_delay_timer;

  localparam int TPU = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [1:0] busy;
    logic [1:0] enable;
    logic [1:0] reject;
    logic       any_busy;
    logic [7:0] remaining;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  multi_delay_timer_if #(.NUM_CH(2), .UNIT_W(4)) bus0();
  multi_delay_timer_if #(.NUM_CH(2), .UNIT_W(4)) bus1();

  multi_delay_timer #(.NUM_CH(2), .UNIT_W(4), .TICKS_PER_UNIT(TPU), .EXCLUSIVE(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multi_delay_timer #(.NUM_CH(2), .UNIT_W(4), .TICKS_PER_UNIT(TPU), .EXCLUSIVE(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         k[2];
  int         u[2];
  logic [1:0] rej_exp;

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic [1:0] st, input logic [1:0] cn,
                                input logic [7:0] un);
    if (sel == 0) begin
      bus0.start = st; bus0.cancel = cn; bus0.units = un;
    end else begin
      bus1.start = st; bus1.cancel = cn; bus1.units = un;
    end
  endtask

  // Expected outputs follow from the delay formula: channel busy for u*TPU
  // cycles, remaining = u - (k-1)/TPU, enable only in the last cycle.
  task automatic push_expect(input int sel, input string tag);
    exp_t e;
    e.tag = tag; e.sel = sel;
    e.busy = '0; e.enable = '0; e.remaining = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (k[ch] > 0) begin
        e.busy[ch] = 1'b1;
        e.remaining[ch*4 +: 4] = 4'(u[ch] - (k[ch] - 1) / TPU);
        e.enable[ch] = (k[ch] == u[ch] * TPU);
      end
    end
    e.any_busy = |e.busy;
    e.reject = rej_exp;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    logic [1:0] ob, oe, orj;
    logic       oa;
    logic [7:0] orem;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        ob = bus0.busy; oe = bus0.enable; orj = bus0.reject; oa = bus0.any_busy; orem = bus0.remaining;
      end else begin
        ob = bus1.busy; oe = bus1.enable; orj = bus1.reject; oa = bus1.any_busy; orem = bus1.remaining;
      end
      compare({e.tag, ".busy"},      8'(ob),   8'(e.busy));
      compare({e.tag, ".enable"},    8'(oe),   8'(e.enable));
      compare({e.tag, ".reject"},    8'(orj),  8'(e.reject));
      compare({e.tag, ".any_busy"},  8'(oa),   8'(e.any_busy));
      compare({e.tag, ".remaining"}, orem,     e.remaining);
    end
  endtask

  task automatic cycle(input int sel, input string tag);
    push_expect(sel, tag);
    @(posedge clk);
    @(negedge clk);
    check_output();
    for (int ch = 0; ch < 2; ch++) begin
      if (k[ch] > 0) begin
        k[ch]++;
        if (k[ch] > u[ch] * TPU) k[ch] = 0;
      end
    end
    rej_exp = '0;
  endtask

  initial begin
    k = '{0, 0}; u = '{0, 0}; rej_exp = '0;
    reset = 1'b1;
    apply_stimulus(0, 2'b11, 2'b00, 8'h22);
    apply_stimulus(1, 2'b00, 2'b00, 8'h00);

    // Start held through reset, accepted on the first edge after release.
    cycle(0, "in_reset_a");
    cycle(0, "in_reset_b");
    reset = 1'b0;
    k = '{1, 1}; u = '{2, 2};
    cycle(0, "rst_accept");
    apply_stimulus(0, 2'b00, 2'b00, 8'h22);
    repeat (7) cycle(0, "rst_run");
    cycle(0, "rst_done");

    // Three-minute delay; units changed after capture must be ignored.
    apply_stimulus(0, 2'b01, 2'b00, 8'h03);
    k[0] = 1; u[0] = 3;
    cycle(0, "u3_accept");
    apply_stimulus(0, 2'b00, 2'b00, 8'h07);
    repeat (11) cycle(0, "u3_run");
    cycle(0, "u3_done");

    // Cancel sampled at the end of busy cycle 5.
    apply_stimulus(0, 2'b01, 2'b00, 8'h03);
    k[0] = 1; u[0] = 3;
    cycle(0, "cx_accept");
    apply_stimulus(0, 2'b00, 2'b00, 8'h03);
    repeat (4) cycle(0, "cx_run");
    apply_stimulus(0, 2'b00, 2'b01, 8'h03);
    k[0] = 0;
    cycle(0, "cx_cancel");
    apply_stimulus(0, 2'b01, 2'b01, 8'h03);
    cycle(0, "cx_coincide");
    apply_stimulus(0, 2'b00, 2'b00, 8'h03);
    cycle(0, "cx_idle");

    // Zero delay is refused with a one-cycle reject.
    apply_stimulus(0, 2'b10, 2'b00, 8'h03);
    rej_exp = 2'b10;
    cycle(0, "zero_reject");
    apply_stimulus(0, 2'b00, 2'b00, 8'h03);
    cycle(0, "zero_after");

    // Start held across expiry: one idle cycle, then re-accepted.
    apply_stimulus(0, 2'b01, 2'b00, 8'h01);
    k[0] = 1; u[0] = 1;
    cycle(0, "hold_accept");
    repeat (3) cycle(0, "hold_run");
    cycle(0, "hold_gap");
    k[0] = 1;
    cycle(0, "hold_reaccept");
    apply_stimulus(0, 2'b00, 2'b00, 8'h01);
    repeat (3) cycle(0, "hold_run2");
    cycle(0, "hold_done");

    // Exclusive instance: arbitration and rejection during enable cycle.
    apply_stimulus(1, 2'b11, 2'b00, 8'h22);
    k[0] = 1; u[0] = 2; rej_exp = 2'b10;
    cycle(1, "ex_both");
    apply_stimulus(1, 2'b00, 2'b00, 8'h22);
    repeat (7) cycle(1, "ex_run0");
    apply_stimulus(1, 2'b10, 2'b00, 8'h22);
    rej_exp = 2'b10;
    cycle(1, "ex_rej_en");
    k[1] = 1; u[1] = 2;
    cycle(1, "ex_accept1");
    apply_stimulus(1, 2'b00, 2'b00, 8'h22);
    repeat (7) cycle(1, "ex_run1");
    cycle(1, "ex_done");

    // Reset between edges clears outputs without waiting for a clock.
    apply_stimulus(0, 2'b01, 2'b00, 8'h03);
    k[0] = 1; u[0] = 3;
    cycle(0, "mr_accept");
    apply_stimulus(0, 2'b00, 2'b00, 8'h03);
    repeat (2) cycle(0, "mr_run");
    #2 reset = 1'b1;
    #1;
    k = '{0, 0};
    push_expect(0, "mr_async");
    check_output();
    cycle(0, "mr_hold");
    reset = 1'b0;
    cycle(0, "mr_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_delay_timer.md
MULTI_DELAY_TIMER -- requirements
Module: multi_delay_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of independent timer channels (>=1).
REQ-002 The block SHALL have parameter UNIT_W, default 8, meaning width of each channel's delay value in "minutes".
REQ-003 The block SHALL have parameter TICKS_PER_UNIT, default 12500000, meaning clk cycles per "minute" (half second at 25 MHz, >=1).
REQ-004 The block SHALL have parameter EXCLUSIVE, default 0, meaning 1 = at most one channel busy at a time.
REQ-005 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port start  input  NUM_CH  per-channel level-sensitive start request.
REQ-008 The block SHALL have port cancel  input  NUM_CH  per-channel abort request.
REQ-009 The block SHALL have port units  input  NUM_CH*UNIT_W  flat per-channel delay in minutes; channel i occupies bits [i*UNIT_W +: UNIT_W].
REQ-010 The block SHALL have port enable  output  NUM_CH  one-cycle pulse marking delay expiry.
REQ-011 The block SHALL have port busy  output  NUM_CH  channel is counting.
REQ-012 The block SHALL have port any_busy  output  1  OR of busy.
REQ-013 The block SHALL have port reject  output  NUM_CH  one-cycle pulse flagging a refused start.
REQ-014 The block SHALL have port remaining  output  NUM_CH*UNIT_W  flat per-channel count of minutes not yet elapsed, same packing as units.

Function
REQ-015 Each channel SHALL run a two-state FSM: IDLE and RUN. Each channel SHALL use a prescaler of width clog2(TICKS_PER_UNIT) and a UNIT_W-bit unit down-counter.
REQ-016 IDLE->RUN SHALL occur at an edge where start[i]=1, cancel[i]=0, units[i]!=0 and the channel is not blocked by REQ-022. At that edge units[i] SHALL be captured; later changes to units SHALL be ignored until the next acceptance.
REQ-017 For N = captured units * TICKS_PER_UNIT, busy[i] SHALL be high for exactly N cycles, beginning at the accepting edge. enable[i] SHALL be high only in the last of those N cycles. RUN->IDLE SHALL occur at the edge ending that cycle.
REQ-018 remaining[i] SHALL equal the captured units at acceptance and SHALL decrement by 1 at each prescaler wrap. It SHALL equal 1 in the enable cycle and 0 whenever IDLE.
REQ-019 start[i] while RUN SHALL be ignored: no restart, no reject. If start[i] is still high at the RUN->IDLE edge, the channel SHALL stay IDLE for one cycle and then be re-accepted at the next edge.
REQ-020 cancel[i]=1 at an edge while RUN SHALL force IDLE, clear remaining[i], and suppress enable. cancel during IDLE SHALL have no effect. When start and cancel coincide, cancel SHALL win and the start SHALL be dropped without reject.
REQ-021 A start with units[i]=0 in IDLE SHALL NOT be accepted. reject[i] SHALL be high for the cycle following that edge.
REQ-022 EXCLUSIVE=1:
- a start SHALL be accepted only if any_busy=0 before the edge, including during a channel's enable cycle;
- among simultaneous valid starts, the lowest index SHALL win;
- every other requesting idle channel SHALL pulse reject.
EXCLUSIVE=0: channels SHALL be fully independent.
REQ-023 enable, busy and reject SHALL be register-derived with no combinational path from inputs. any_busy SHALL be combinational from busy.
REQ-024 Counters SHALL never wrap: a unit counter SHALL stop at 0, and a prescaler SHALL reset to 0 on every acceptance and every cancel.

Reset
REQ-025 While reset=1, all channels SHALL be IDLE with prescalers and counters at 0. enable, busy, any_busy, reject and remaining SHALL all be 0, taking effect immediately without a clock edge.
REQ-026 After reset deasserts, the first edge SHALL behave as a normal IDLE edge; a start held high through reset SHALL be accepted at that edge.

Verification (NUM_CH=2, UNIT_W=4, TICKS_PER_UNIT=4)
REQ-027 The bench SHALL cover: assert reset, then drive start=2'b11 -> all outputs 0 throughout reset; ch0/ch1 accepted at the first edge after release.
REQ-028 The bench SHALL cover: ch0 units=3, start pulsed 1 cycle -> busy[0] high 12 cycles, enable[0] in cycle 12 only, remaining[0] = 3,3,3,3,2,2,2,2,1,1,1,1, then 0.
REQ-029 The bench SHALL cover: ch0 units=3 started, cancel[0] pulsed in busy cycle 5 -> busy[0] low from the next edge, remaining[0]=0, no enable[0].
REQ-030 The bench SHALL cover: ch1 units=0, start pulsed -> reject[1] one cycle, busy[1] stays 0.
REQ-031 The bench SHALL cover: EXCLUSIVE=1, start=2'b11 with both units=2 -> ch0 accepted, reject[1] pulses. ch1 start during ch0's enable cycle -> reject[1]. ch1 start the following cycle -> accepted.
REQ-032 The bench SHALL cover: ch0 running, reset asserted mid-cycle between edges -> busy, remaining and enable drop to 0 before the next edge.
